izh_neuron_scheduler: RTL and testbench
=======================================

// Module: izh_neuron_scheduler
// PURPOSE
//  Time-multiplexes one Izhikevich update datapath across N_NEURONS neurons.
//  Holds per-neuron v/u state, runs one full population sweep per start pulse, and emits spike events.
//  Sits between the network timestep controller (start/done) and the synaptic input/spike-routing logic.
// PARAMETERS
//  N_NEURONS  16                     neurons served per sweep (>=2)
//  DW         16                     state/config width, signed Q8.8
//  IDX_W      $clog2(N_NEURONS)      neuron index width
// PORTS
//  clk          in   1      single clock, rising edge
//  rst          in   1      asynchronous, active-high reset
//  start        in   1      pulse: begin one timestep sweep (ignored while busy)
//  cfg_a        in   DW     recovery time scale a (Q8.8)
//  cfg_b        in   DW     u sensitivity b (Q8.8)
//  cfg_c        in   DW     post-spike v reset (Q8.8)
//  cfg_d        in   DW     post-spike u increment (Q8.8)
//  cfg_dt       in   DW     time step dt (Q8.8)
//  i_idx        out  IDX_W  neuron whose input current is requested
//  i_val        in   DW     input current for i_idx (Q8.8), valid same cycle
//  busy         out  1      high from the cycle after start through done
//  done         out  1      one-cycle pulse, sweep finished
//  spike_valid  out  1      one-cycle pulse per spiking neuron
//  spike_idx    out  IDX_W  index of the spiking neuron, valid with spike_valid
//  rd_idx       in   IDX_W  host state readout address
//  rd_v         out  DW     v[rd_idx], combinational from state array
//  rd_u         out  DW     u[rd_idx], combinational from state array
// BEHAVIOUR
//  Reset (async): FSM->IDLE, idx=0, busy=done=spike_valid=0, spike_idx=0, i_idx=0;
//   all v[k]=V_INIT(-65.0=0xBF00), u[k]=U_INIT(-13.0=0xF300). A reset mid-sweep abandons it; no done is issued.
//  start in IDLE: latch cfg_* into shadow regs (config changes mid-sweep have no effect); idx=0; ->READ.
//  FSM per neuron: READ (i_idx=idx; latch v[idx], u[idx], i_val) -> CALC (register datapath result)
//   -> WRITE (write back, spike check, spike pulse) -> READ for idx+1, or ->DONE after idx=N_NEURONS-1.
//  DONE: done=1 for one cycle, busy=0 in the same cycle, ->IDLE. Sweep latency start->done = 3*N_NEURONS+1 cycles.
//  start while busy or in DONE is dropped (not queued).
//  Arithmetic: all Q8.8, 32-bit signed intermediates, every product rescaled >>>8 immediately:
//   v2 = (v*v)>>>8;  f = ((K004*v2)>>>8) + ((K5*v)>>>8) + K140 - u + I
//   v_n = v + ((dt*f)>>>8);  u_n = u + ((dt*((a*(((b*v)>>>8) - u))>>>8))>>>8)
//   v_n and u_n saturate to [-32768, 32767]; u update uses the pre-update v.
//  Spike (in WRITE): if v_n >= V_PEAK (30.0=7680): v[idx]<=c, u[idx]<=sat(u_n+d),
//   spike_valid=1, spike_idx=idx. Otherwise v[idx]<=v_n, u[idx]<=u_n, spike_valid=0.
//  rd_v/rd_u show the pre-write value during WRITE and the new value from the next cycle.
//  Exactly one neuron is written per WRITE; no neuron is skipped or updated twice per sweep.
// STRUCTURE
//  Package izh_pkg: Q8.8 constants K004=10, K5=1280, K140=35840, V_PEAK, V_INIT, U_INIT;
//   FSM state enum {IDLE, READ, CALC, WRITE, DONE}; function sat16(32-bit signed)->16-bit signed.
//  Sub-module izh_update_unit: combinational v_n/u_n/spike computation from (v,u,I,a,b,dt);
//   the scheduler registers its outputs in CALC. Holds the state arrays, FSM, idx counter, and config shadow.
// TESTING
//  1 Reset then start, i_val=0, a=0.02(5) b=0.2(51) dt=1.0(256): done exactly 49 cycles after start (N=16);
//    no spikes; rd_v/rd_u of every neuron match the golden-model single-step values.
//  2 i_val=10.0(2560) for idx 3 only, repeated sweeps: first spike_valid with spike_idx=3; same cycle v[3]<=c,
//    u[3]<=u_n+d; no spikes from any other neuron.
//  3 Large v via i_val=127.0 and dt=127.0: v_n saturates at 32767 (no wrap), spike fires, v reset to c.
//  4 start pulsed again at cycle 10 of a sweep, and cfg_c changed mid-sweep: exactly one done;
//    resets use the latched c.
//  5 Assert rst at cycle 20 of a sweep: busy/done/spike_valid drop immediately; all v=0xBF00, u=0xF300;
//    a new start then completes normally.
//  6 Compare 100 sweeps with random i_val/cfg against the reference model, bit-exact: spike list and final v/u.

Source files
------------

// File: rtl/izh_pkg.sv
// Shared constants, FSM encoding and saturation helper for the
// time-multiplexed Izhikevich neuron scheduler (all values signed Q8.8).
package izh_pkg;

    localparam int K004 = 10;
    localparam int K5   = 1280;
    localparam int K140 = 35840;

    localparam logic signed [15:0] V_PEAK = 16'sd7680;
    localparam logic signed [15:0] V_INIT = 16'shBF00;
    localparam logic signed [15:0] U_INIT = 16'shF300;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        CALC,
        WRITE,
        DONE
    } state_t;

    function automatic logic signed [15:0] sat16(input logic signed [31:0] x);
        if (x > 32'sd32767) begin
            return 16'sh7FFF;
        end else if (x < -32'sd32768) begin
            return 16'sh8000;
        end else begin
            return x[15:0];
        end
    endfunction

endpackage

// File: rtl/izh_update_unit.sv
// Combinational single-step Izhikevich update: next v/u and the spike flag.
// Every product is formed at 32 bits and rescaled by 8 before use.
module izh_update_unit
    import izh_pkg::*;
(
    input  logic signed [15:0] i_v,
    input  logic signed [15:0] i_u,
    input  logic signed [15:0] i_cur,
    input  logic signed [15:0] i_a,
    input  logic signed [15:0] i_b,
    input  logic signed [15:0] i_dt,
    output logic signed [15:0] o_vn,
    output logic signed [15:0] o_un,
    output logic               o_spike
);

    logic signed [31:0] w_v;
    logic signed [31:0] w_u;
    logic signed [31:0] w_i;
    logic signed [31:0] w_a;
    logic signed [31:0] w_b;
    logic signed [31:0] w_dt;
    logic signed [31:0] w_v2;
    logic signed [31:0] w_f;
    logic signed [31:0] w_vn;
    logic signed [31:0] w_bvu;
    logic signed [31:0] w_du;
    logic signed [31:0] w_un;

    assign w_v  = 32'(i_v);
    assign w_u  = 32'(i_u);
    assign w_i  = 32'(i_cur);
    assign w_a  = 32'(i_a);
    assign w_b  = 32'(i_b);
    assign w_dt = 32'(i_dt);

    assign w_v2 = (w_v * w_v) >>> 8;
    assign w_f  = ((K004 * w_v2) >>> 8) + ((K5 * w_v) >>> 8)
                + K140 - w_u + w_i;
    assign w_vn = w_v + ((w_dt * w_f) >>> 8);

    // Recovery variable is driven by the pre-update membrane potential.
    assign w_bvu = ((w_b * w_v) >>> 8) - w_u;
    assign w_du  = (w_a * w_bvu) >>> 8;
    assign w_un  = w_u + ((w_dt * w_du) >>> 8);

    assign o_vn    = sat16(w_vn);
    assign o_un    = sat16(w_un);
    assign o_spike = (o_vn >= V_PEAK);

endmodule

// File: rtl/izh_neuron_scheduler.sv
// Sweeps one shared Izhikevich update unit over all neurons per start pulse,
// holding per-neuron v/u state and emitting a spike event per firing neuron.
module izh_neuron_scheduler
    import izh_pkg::*;
#(
    parameter int N_NEURONS = 16,
    parameter int DW        = 16,
    parameter int IDX_W     = $clog2(N_NEURONS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [DW-1:0]    cfg_a,
    input  logic [DW-1:0]    cfg_b,
    input  logic [DW-1:0]    cfg_c,
    input  logic [DW-1:0]    cfg_d,
    input  logic [DW-1:0]    cfg_dt,
    output logic [IDX_W-1:0] i_idx,
    input  logic [DW-1:0]    i_val,
    output logic             busy,
    output logic             done,
    output logic             spike_valid,
    output logic [IDX_W-1:0] spike_idx,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [DW-1:0]    rd_v,
    output logic [DW-1:0]    rd_u
);

    state_t r_state;
    state_t w_next;

    logic [IDX_W-1:0]     r_idx;
    logic signed [DW-1:0] r_a, r_b, r_c, r_d, r_dt;
    logic signed [DW-1:0] r_v, r_u, r_i;
    logic signed [DW-1:0] r_vn, r_un;
    logic                 r_spk;
    logic signed [DW-1:0] r_vmem [N_NEURONS];
    logic signed [DW-1:0] r_umem [N_NEURONS];

    logic signed [DW-1:0] w_vn, w_un, w_ud;
    logic                 w_spk;
    logic                 w_last;

    izh_update_unit u_update (
        .i_v     (r_v),
        .i_u     (r_u),
        .i_cur   (r_i),
        .i_a     (r_a),
        .i_b     (r_b),
        .i_dt    (r_dt),
        .o_vn    (w_vn),
        .o_un    (w_un),
        .o_spike (w_spk)
    );

    assign w_last = (r_idx == IDX_W'(N_NEURONS - 1));
    assign w_ud   = sat16(32'(r_un) + 32'(r_d));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (start) w_next = READ;
            READ:    w_next = CALC;
            CALC:    w_next = WRITE;
            WRITE:   w_next = w_last ? DONE : READ;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx <= '0;
            r_a   <= '0;
            r_b   <= '0;
            r_c   <= '0;
            r_d   <= '0;
            r_dt  <= '0;
            r_v   <= '0;
            r_u   <= '0;
            r_i   <= '0;
            r_vn  <= '0;
            r_un  <= '0;
            r_spk <= 1'b0;
            for (int k = 0; k < N_NEURONS; k++) begin
                r_vmem[k] <= V_INIT;
                r_umem[k] <= U_INIT;
            end
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (start) begin
                        r_a   <= cfg_a;
                        r_b   <= cfg_b;
                        r_c   <= cfg_c;
                        r_d   <= cfg_d;
                        r_dt  <= cfg_dt;
                        r_idx <= '0;
                    end
                end
                READ: begin
                    r_v <= r_vmem[r_idx];
                    r_u <= r_umem[r_idx];
                    r_i <= i_val;
                end
                CALC: begin
                    r_vn  <= w_vn;
                    r_un  <= w_un;
                    r_spk <= w_spk;
                end
                WRITE: begin
                    if (r_spk) begin
                        r_vmem[r_idx] <= r_c;
                        r_umem[r_idx] <= w_ud;
                    end else begin
                        r_vmem[r_idx] <= r_vn;
                        r_umem[r_idx] <= r_un;
                    end
                    if (!w_last) r_idx <= r_idx + IDX_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign i_idx       = r_idx;
    assign busy        = (r_state == READ) || (r_state == CALC)
                      || (r_state == WRITE);
    assign done        = (r_state == DONE);
    assign spike_valid = (r_state == WRITE) && r_spk;
    assign spike_idx   = spike_valid ? r_idx : '0;
    assign rd_v        = r_vmem[rd_idx];
    assign rd_u        = r_umem[rd_idx];

endmodule

// File: tb/tb_izh_neuron_scheduler.sv
// Bench for izh_neuron_scheduler: hand vectors, corner sequences and
// randomized sweeps against an arithmetic reference of the neuron equations.
module tb_izh_neuron_scheduler;

    localparam int N = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [15:0] cfg_a = '0, cfg_b = '0, cfg_c = '0, cfg_d = '0, cfg_dt = '0;
    logic [3:0]  i_idx;
    logic [15:0] i_val;
    logic        busy, done, spike_valid;
    logic [3:0]  spike_idx;
    logic [3:0]  rd_idx = '0;
    logic [15:0] rd_v, rd_u;

    logic [15:0] cur [N];

    assign i_val = cur[i_idx];

    izh_neuron_scheduler #(.N_NEURONS(N), .DW(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .cfg_a       (cfg_a),
        .cfg_b       (cfg_b),
        .cfg_c       (cfg_c),
        .cfg_d       (cfg_d),
        .cfg_dt      (cfg_dt),
        .i_idx       (i_idx),
        .i_val       (i_val),
        .busy        (busy),
        .done        (done),
        .spike_valid (spike_valid),
        .spike_idx   (spike_idx),
        .rd_idx      (rd_idx),
        .rd_v        (rd_v),
        .rd_u        (rd_u)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int mv [N];
    int mu [N];
    int exp_q [$];
    int got_q [$];
    int done_cnt = 0;

    always @(negedge clk) begin
        if (spike_valid) got_q.push_back(int'(spike_idx));
        if (done) done_cnt++;
    end

    task automatic chk(input string nm, input int act, input int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d, required %0d", nm, act, req);
        end
    endtask

    function automatic int sat(input int x);
        if (x > 32767) return 32767;
        if (x < -32768) return -32768;
        return x;
    endfunction

    function automatic int s16(input logic [15:0] x);
        return int'($signed(x));
    endfunction

    task automatic model_init();
        for (int k = 0; k < N; k++) begin
            mv[k] = -16640;
            mu[k] = -3328;
        end
    endtask

    // One timestep of every neuron, straight from the Q8.8 equations.
    task automatic model_sweep(input int a, input int b, input int c,
                               input int d, input int dt);
        int v, u, f, vn, un;
        for (int k = 0; k < N; k++) begin
            v  = mv[k];
            u  = mu[k];
            f  = ((10 * ((v * v) >>> 8)) >>> 8) + ((1280 * v) >>> 8)
               + 35840 - u + s16(cur[k]);
            vn = sat(v + ((dt * f) >>> 8));
            un = sat(u + ((dt * ((a * (((b * v) >>> 8) - u)) >>> 8)) >>> 8));
            if (vn >= 7680) begin
                mv[k] = c;
                mu[k] = sat(un + d);
                exp_q.push_back(k);
            end else begin
                mv[k] = vn;
                mu[k] = un;
            end
        end
    endtask

    task automatic check_state(input string nm);
        int bad = 0;
        for (int k = 0; k < N; k++) begin
            rd_idx = 4'(k);
            #1;
            if (s16(rd_v) != mv[k] || s16(rd_u) != mu[k]) begin
                if (bad == 0)
                    $display("FAIL %s_state: neuron %0d v=%0d u=%0d, required v=%0d u=%0d",
                             nm, k, s16(rd_v), s16(rd_u), mv[k], mu[k]);
                bad++;
            end
        end
        tests++;
        if (bad != 0) fails++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_init();
        got_q.delete();
        exp_q.delete();
    endtask

    // Pulses start, waits for done (bounded), then checks spikes and state.
    task automatic sweep(input string nm, output int lat);
        bit ok = 0;
        int bad = 0;
        lat = 0;
        got_q.delete();
        exp_q.delete();
        model_sweep(s16(cfg_a), s16(cfg_b), s16(cfg_c), s16(cfg_d), s16(cfg_dt));
        @(negedge clk);
        start = 1'b1;
        for (int n = 1; n <= 200; n++) begin
            @(posedge clk);
            #1 start = 1'b0;
            @(negedge clk);
            if (done) begin
                lat = n;
                ok = 1;
                break;
            end
        end
        if (!ok) chk({nm, "_timeout"}, 0, 1);
        if (got_q.size() != exp_q.size()) begin
            bad = 1;
        end else begin
            for (int k = 0; k < got_q.size(); k++)
                if (got_q[k] != exp_q[k]) bad++;
        end
        if (bad != 0)
            $display("FAIL %s_spikes: got %0d events, required %0d",
                     nm, got_q.size(), exp_q.size());
        tests++;
        if (bad != 0) fails++;
        check_state(nm);
    endtask

    typedef struct {
        int ival;
        int a;
        int b;
        int c;
        int d;
        int dt;
        int ev;
        int eu;
        int espk;
    } vec_t;

    vec_t tbl [6];

    initial begin
        int lat, d0, nsp;
        for (int k = 0; k < N; k++) cur[k] = '0;

        tbl[0] = '{0,     5,   51,  -16640, 2048, 256,   -18422, -3328,  0};
        tbl[1] = '{2560,  5,   51,  -16640, 2048, 256,   -15862, -3328,  0};
        tbl[2] = '{32512, 5,   51,  -12800, 2048, 32512, -12800, -1280,  1};
        tbl[3] = '{0,     256, 512, -16640, 2048, 256,   -18422, -32768, 0};
        tbl[4] = '{0,     5,   51,  -16640, 2048, 0,     -16640, -3328,  0};
        tbl[5] = '{-2560, 5,   51,  -16640, 2048, 128,   -18811, -3328,  0};

        // Reset values.
        rst = 1'b1;
        #12;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_spike_valid", int'(spike_valid), 0);
        chk("rst_i_idx", int'(i_idx), 0);
        model_init();
        check_state("rst");
        rst = 1'b0;

        // Single sweep from reset, hand-derived neuron 0 results.
        for (int t = 0; t < 6; t++) begin
            do_reset();
            for (int k = 0; k < N; k++) cur[k] = 16'(tbl[t].ival);
            cfg_a  = 16'(tbl[t].a);
            cfg_b  = 16'(tbl[t].b);
            cfg_c  = 16'(tbl[t].c);
            cfg_d  = 16'(tbl[t].d);
            cfg_dt = 16'(tbl[t].dt);
            sweep($sformatf("vec%0d", t), lat);
            chk($sformatf("vec%0d_latency", t), lat, 3 * N + 1);
            rd_idx = 4'd0;
            #1;
            chk($sformatf("vec%0d_v0", t), s16(rd_v), tbl[t].ev);
            chk($sformatf("vec%0d_u0", t), s16(rd_u), tbl[t].eu);
            chk($sformatf("vec%0d_nspk", t), got_q.size(), tbl[t].espk * N);
        end

        // Only neuron 3 is driven; first spike must come from it.
        do_reset();
        cfg_a = 16'd5; cfg_b = 16'd51; cfg_c = 16'(-16640);
        cfg_d = 16'd2048; cfg_dt = 16'd256;
        for (int k = 0; k < N; k++) cur[k] = '0;
        cur[3] = 16'd2560;
        nsp = 0;
        for (int s = 0; s < 100; s++) begin
            sweep($sformatf("t2_s%0d", s), lat);
            if (got_q.size() > 0) begin
                nsp = got_q.size();
                break;
            end
        end
        chk("t2_spike_count", nsp, 1);
        if (nsp > 0) begin
            chk("t2_spike_idx", got_q[0], 3);
            rd_idx = 4'd3;
            #1;
            chk("t2_v3_reset", s16(rd_v), -16640);
        end

        // Second start and cfg_c change mid-sweep must be ignored.
        do_reset();
        for (int k = 0; k < N; k++) cur[k] = 16'd32512;
        cfg_a = 16'd5; cfg_b = 16'd51; cfg_c = 16'(-12800);
        cfg_d = 16'd2048; cfg_dt = 16'd32512;
        model_sweep(5, 51, -12800, 2048, 32512);
        d0 = done_cnt;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        start = 1'b1;
        cfg_c = 16'(-5000);
        @(posedge clk);
        #1 start = 1'b0;
        repeat (60) @(posedge clk);
        @(negedge clk);
        chk("t4_done_count", done_cnt - d0, 1);
        chk("t4_busy_after", int'(busy), 0);
        chk("t4_spike_count", got_q.size(), N);
        check_state("t4");
        cfg_c = 16'(-12800);

        // Asynchronous reset in the middle of a sweep.
        got_q.delete();
        d0 = done_cnt;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (19) @(posedge clk);
        #1;
        chk("t5_busy_before", int'(busy), 1);
        #1 rst = 1'b1;
        #1;
        chk("t5_busy", int'(busy), 0);
        chk("t5_done", int'(done), 0);
        chk("t5_spike_valid", int'(spike_valid), 0);
        model_init();
        check_state("t5_rst");
        @(negedge clk);
        rst = 1'b0;
        repeat (40) @(posedge clk);
        @(negedge clk);
        chk("t5_no_done", done_cnt - d0, 0);
        sweep("t5_after", lat);
        chk("t5_after_latency", lat, 3 * N + 1);

        // Randomized sweeps against the reference model.
        do_reset();
        for (int s = 0; s < 100; s++) begin
            cfg_a  = 16'($urandom_range(0, 64));
            cfg_b  = 16'($urandom_range(0, 128));
            cfg_c  = 16'(-int'($urandom_range(8000, 20000)));
            cfg_d  = 16'($urandom_range(0, 4096));
            cfg_dt = 16'($urandom_range(0, 512));
            for (int k = 0; k < N; k++)
                cur[k] = 16'(int'($urandom_range(0, 12288)) - 4096);
            sweep($sformatf("rand%0d", s), lat);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
